// File: rtl/rs_latch_ctrl.sv
// Arbitrated two-requester controller that writes an external NAND RS latch
// with a timed active-low pulse, lets it settle, then verifies Q.
module rs_latch_ctrl #(
    parameter int PULSE_W  = 2,
    parameter int SETTLE_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req0_val,
    output logic req0_ready,
    input  logic req1_valid,
    input  logic req1_val,
    output logic req1_ready,
    output logic s_n,
    output logic r_n,
    input  logic q,
    output logic busy,
    output logic done,
    output logic err,
    output logic owner
);

    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       val_r, val_nx;
    logic       owner_nx;
    logic       q_m, q_s;
    logic       grant0, grant1;

    // q is asynchronous to clk, so it only enters the FSM through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m <= 1'b0;
            q_s <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let q_m and q_s form a real
            // two-stage pipeline; blocking ones would collapse it to one flop.
            q_m <= q;
            q_s <= q_m;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        val_nx   = val_r;
        owner_nx = owner;
        grant0   = 1'b0;
        grant1   = 1'b0;
        unique case (state)
            IDLE: begin
                // A tie goes to the requester that was not served last.
                grant0 = req0_valid && (!req1_valid || owner);
                grant1 = req1_valid && (!req0_valid || !owner);
                if (grant0 || grant1) begin
                    state_nx = PULSE;
                    cnt_nx   = 4'(PULSE_W - 1);
                    val_nx   = grant0 ? req0_val : req1_val;
                    owner_nx = grant1;
                end
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    state_nx = SETTLE;
                    cnt_nx   = 4'(SETTLE_W - 1);
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) state_nx = CHECK;
                else             cnt_nx   = cnt - 4'd1;
            end
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the asynchronous reset forces the latch drive inactive the moment
    // rst rises, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            val_r <= 1'b0;
            owner <= 1'b1;
            s_n   <= 1'b1;
            r_n   <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            val_r <= val_nx;
            owner <= owner_nx;
            // Decoded from the next state so the drive lines up with PULSE;
            // a single val bit selects the line, so both can never be low.
            s_n   <= !((state_nx == PULSE) && val_nx);
            r_n   <= !((state_nx == PULSE) && !val_nx);
        end
    end

    assign req0_ready = grant0 && !rst;
    assign req1_ready = grant1 && !rst;
    assign busy       = (state != IDLE);
    assign done       = (state == CHECK);
    assign err        = done && (q_s != val_r);

endmodule

// File: tb/tb_rs_latch_ctrl.sv
// Bench for rs_latch_ctrl: NAND latch model, offset-based transaction model,
// directed scenarios followed by random traffic.
module tb_rs_latch_ctrl;

    localparam int PW = 2;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic v0 = 1'b0, d0 = 1'b0, v1 = 1'b0, d1 = 1'b0;
    logic rdy0, rdy1, s_n, r_n, q, busy, done, err, owner;

    // Cross-coupled NAND latch; stuck forces the observed Q low.
    logic qa = 1'b0, qb = 1'b1, stuck = 1'b0;
    always @(s_n or qb) qa <= #1 ~(s_n & qb);
    always @(r_n or qa) qb <= #1 ~(r_n & qa);
    assign q = stuck ? 1'b0 : qa;

    int total = 0, bad = 0, cyc = 0;

    // Model: cycles elapsed since the accept (0 = idle), target value, owner.
    int   m_off   = 0;
    logic m_val   = 1'b0;
    logic m_owner = 1'b1;

    int   g_cyc[$];
    logic g_who[$];
    logic rec = 1'b0;

    rs_latch_ctrl #(.PULSE_W(PW), .SETTLE_W(SW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_val(d0), .req0_ready(rdy0),
        .req1_valid(v1), .req1_val(d1), .req1_ready(rdy1),
        .s_n(s_n), .r_n(r_n), .q(q),
        .busy(busy), .done(done), .err(err), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare one cycle at the falling edge, advance the model, return just
    // after the next rising edge so the caller can drive new inputs.
    task automatic step();
        logic idle, e0, e1, in_pulse, chk;
        @(negedge clk);
        idle     = (m_off == 0);
        e0       = idle && v0 && (!v1 || m_owner);
        e1       = idle && v1 && (!v0 || !m_owner);
        in_pulse = (m_off >= 1) && (m_off <= PW);
        chk      = (m_off == PW + SW + 1);
        check("ready0", 32'(rdy0), 32'(e0));
        check("ready1", 32'(rdy1), 32'(e1));
        check("s_n", 32'(s_n), 32'(!(in_pulse && m_val)));
        check("r_n", 32'(r_n), 32'(!(in_pulse && !m_val)));
        check("busy", 32'(busy), 32'(!idle));
        check("done", 32'(done), 32'(chk));
        check("err", 32'(err), 32'(chk && stuck && m_val));
        check("owner", 32'(owner), 32'(m_owner));
        check("no_overlap", 32'(s_n || r_n), 32'd1);
        if (rec && (rdy0 || rdy1)) begin
            g_cyc.push_back(cyc);
            g_who.push_back(rdy1);
        end
        if (e0 || e1) begin
            m_off   = 1;
            m_val   = e0 ? d0 : d1;
            m_owner = e1;
        end else if (chk) begin
            m_off = 0;
        end else if (!idle) begin
            m_off++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asserts rst between edges, checks the forced outputs, releases after a
    // rising edge has passed under reset.
    task automatic do_reset();
        v0  = 1'b1;
        v1  = 1'b1;
        rst = 1'b1;
        #2;
        check("rst_s_n", 32'(s_n), 32'd1);
        check("rst_r_n", 32'(r_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready0", 32'(rdy0), 32'd0);
        check("rst_ready1", 32'(rdy1), 32'd0);
        check("rst_owner", 32'(owner), 32'd1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_off   = 0;
        m_val   = 1'b0;
        m_owner = 1'b1;
        v0      = 1'b0;
        v1      = 1'b0;
    endtask

    initial begin
        do_reset();

        // Lone set from req0, then q must read back high.
        v0 = 1'b1; d0 = 1'b1; step(); v0 = 1'b0;
        repeat (PW + SW + 1) step();
        check("q_after_set", 32'(q), 32'd1);

        // Rewrite of the value already held: full sequence, no error.
        v1 = 1'b1; d1 = 1'b1; step(); v1 = 1'b0;
        repeat (PW + SW + 1) step();

        // Clear, so the stuck test below really has a mismatch to detect.
        v0 = 1'b1; d0 = 1'b0; step(); v0 = 1'b0;
        repeat (PW + SW + 1) step();

        // Q stuck low during a set write.
        stuck = 1'b1;
        v0 = 1'b1; d0 = 1'b1; step(); v0 = 1'b0;
        repeat (PW + SW + 1) step();
        stuck = 1'b0;
        repeat (3) step();

        // Reset during the second pulse cycle, then a normal write.
        v0 = 1'b1; d0 = 1'b1; step(); v0 = 1'b0;
        step();
        check("pulse2_s_n", 32'(s_n), 32'd0);
        do_reset();
        v1 = 1'b1; d1 = 1'b0; step(); v1 = 1'b0;
        repeat (PW + SW + 1) step();

        // Both requesters held from reset: alternating grants, fixed spacing.
        do_reset();
        v0 = 1'b1; d0 = 1'b0; v1 = 1'b1; d1 = 1'b1;
        rec = 1'b1;
        repeat (3 * (PW + SW + 2) + 1) step();
        rec = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        check("rr_grants", 32'(g_who.size() >= 3), 32'd1);
        if (g_who.size() >= 3) begin
            check("rr_first", 32'(g_who[0]), 32'd0);
            check("rr_second", 32'(g_who[1]), 32'd1);
            check("rr_third", 32'(g_who[2]), 32'd0);
            check("rr_gap1", 32'(g_cyc[1] - g_cyc[0]), 32'(PW + SW + 2));
            check("rr_gap2", 32'(g_cyc[2] - g_cyc[1]), 32'(PW + SW + 2));
        end

        // Random traffic with occasional resets.
        repeat (10000) begin
            v0 = 1'($urandom_range(0, 1));
            d0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            d1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) do_reset();
            else                             step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_latch_ctrl.md
RS_LATCH_CTRL -- requirements
Module: rs_latch_ctrl

Interface
REQ-001 SHALL have parameter PULSE_W, default 2: cycles the latch input is held active (legal 1..15).
REQ-002 SHALL have parameter SETTLE_W, default 3: cycles waited after the pulse before Q is checked (legal 2..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req0_valid  input  1  requester 0 has a pending write.
REQ-006 SHALL have port req0_val  input  1  requester 0 target value (1=set, 0=clear).
REQ-007 SHALL have port req0_ready  output  1  one-cycle accept strobe for requester 0.
REQ-008 SHALL have ports req1_valid, req1_val and req1_ready, identical in form to the req0 ports, for requester 1.
REQ-009 SHALL have port s_n  output  1  active-low set input to the NAND latch.
REQ-010 SHALL have port r_n  output  1  active-low reset input to the NAND latch.
REQ-011 SHALL have port q  input  1  latch Q feedback, asynchronous to clk.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle strobe when a write completes.
REQ-014 SHALL have port err  output  1  one-cycle strobe, coincident with done, when Q mismatches the target.
REQ-015 SHALL have port owner  output  1  index of the requester currently or last granted.

Function
REQ-016 SHALL synchronise q through two flops (q_s) before any use.
REQ-017 SHALL implement the FSM states IDLE, PULSE, SETTLE and CHECK.
REQ-018 In IDLE with any valid, SHALL grant one requester, pulse its ready for that cycle, latch val and owner, load the counter with PULSE_W-1, and go to PULSE.
REQ-019 Arbitration SHALL grant a lone requester directly; if both are valid, the requester not equal to owner wins (round-robin).
REQ-020 A request is accepted only on the cycle valid&ready; valid is not sampled in any other state.
REQ-021 In PULSE, SHALL drive s_n=0 for val=1 or r_n=0 for val=0, the other output held at 1, for exactly PULSE_W cycles, then go to SETTLE with the counter reloaded to SETTLE_W-1.
REQ-022 In SETTLE, both s_n and r_n SHALL be 1 for exactly SETTLE_W cycles, then go to CHECK.
REQ-023 CHECK SHALL last one cycle: assert done, assert err if q_s != val, then return to IDLE.
REQ-024 A new grant SHALL occur no earlier than the cycle after CHECK; minimum spacing between accepts is PULSE_W+SETTLE_W+2 cycles.
REQ-025 s_n and r_n SHALL be registered outputs and SHALL never be 0 in the same cycle, including across reset and state changes.
REQ-026 A repeated write of the current latch value SHALL still be executed in full, with err=0.
REQ-027 A valid deasserted after its accept SHALL have no effect on the operation in progress.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force state=IDLE, s_n=1, r_n=1, busy=0, done=0, err=0, both ready=0, owner=1 (so req0 wins the first tie), counter=0 and sync flops=0.
REQ-029 rst asserted mid-PULSE SHALL release the latch input within the same reset assertion; the aborted write produces no done, and it is not retried.
REQ-030 After rst falls, the first grant SHALL be possible on the first clk edge.

Verification
REQ-031 The bench SHALL connect a gate-level NAND latch model with 1-cycle-or-less delay to s_n/r_n/q, with PULSE_W=2 and SETTLE_W=3.
REQ-032 Stimulus req0 set alone at t0 -> req0_ready at t0, s_n=0 at t1-t2, done=1 and err=0 at t6, q=1.
REQ-033 Stimulus req0 clear and req1 set held continuously from reset -> grants alternate req0, req1, req0, and the accepts are 7 cycles apart.
REQ-034 Stimulus with q forced stuck at 0 and a set write -> done=1 and err=1 in CHECK.
REQ-035 Stimulus rst pulsed during the second PULSE cycle -> s_n=1 immediately, no done, busy=0, and the next request is served normally.
REQ-036 The assertion !s_n && !r_n is never true, checked on random traffic over 10k cycles.
